// File: rtl/pc_ctrl_if.sv
// EX-stage branch resolution bus: the execute stage (master) reports resolved
// control flow and the PC controller (slave) answers with a flush request.
interface pc_ctrl_if;
   logic        ex_valid;
   logic        ex_is_branch;
   logic        ex_is_jump;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        flush;

   modport master (
      output ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_taken, ex_target,
             ex_pred_taken, ex_pred_target,
      input  flush
   );

   modport slave (
      input  ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_taken, ex_target,
             ex_pred_taken, ex_pred_target,
      output flush
   );
endinterface

// File: rtl/pc_ctrl.sv
// Fetch PC controller with a direct-mapped BTB of 2-bit saturating counters.
// Define PC_CTRL_PERF_EN to build the branch/mispredict performance counters.
module pc_ctrl #(
   parameter int unsigned BTB_ENTRIES = 16,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   pc_ctrl_if.slave    ex_if,
   output logic [31:0] pc_o,
   output logic        pred_taken_o,
   output logic [31:0] pred_target_o,
   output logic [31:0] perf_branches_o,
   output logic [31:0] perf_mispredicts_o
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 32 - IDX_W - 2;

   typedef enum logic {S_HOLD, S_RUN} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;

   logic             valid_q  [BTB_ENTRIES];
   logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
   logic [31:0]      target_q [BTB_ENTRIES];
   logic [1:0]       ctr_q    [BTB_ENTRIES];

   logic [IDX_W-1:0] lookupIdx, updIdx;
   logic [TAG_W-1:0] lookupTag, updTag;
   logic             lookupHit, updHit;
   logic [31:0]      pcPlus4, correctedPc;
   logic             predTaken;
   logic [31:0]      predTarget;
   logic             resolve, mispredict;
   logic             btbWrite;
   logic [1:0]       newCtr;
   logic [31:0]      newTarget;

   assign lookupIdx = pc_q[IDX_W+1:2];
   assign lookupTag = pc_q[31:IDX_W+2];
   assign lookupHit = valid_q[lookupIdx] && (tag_q[lookupIdx] == lookupTag);
   assign pcPlus4   = pc_q + 32'd4;

   assign predTaken  = lookupHit && ctr_q[lookupIdx][1] && (state_q == S_RUN);
   assign predTarget = lookupHit ? target_q[lookupIdx] : pcPlus4;

   assign resolve     = ex_if.ex_valid && (ex_if.ex_is_branch || ex_if.ex_is_jump);
   assign mispredict  = resolve &&
                        ((ex_if.ex_taken != ex_if.ex_pred_taken) ||
                         (ex_if.ex_taken && (ex_if.ex_target != ex_if.ex_pred_target)));
   assign correctedPc = ex_if.ex_taken ? ex_if.ex_target : (ex_if.ex_pc + 32'd4);

   // Outputs are forced quiet while reset is held, independent of bus activity.
   assign pc_o          = pc_q;
   assign pred_taken_o  = rst_n && predTaken;
   assign pred_target_o = rst_n ? predTarget : 32'h0;
   assign ex_if.flush   = rst_n && mispredict;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_HOLD;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      unique case (state_q)
         S_HOLD: state_d = S_RUN;
         S_RUN: begin
            if (mispredict) begin
               pc_d = correctedPc;
            end else if (!stall_i) begin
               pc_d = predTaken ? predTarget : pcPlus4;
            end
         end
      endcase
   end

   assign updIdx = ex_if.ex_pc[IDX_W+1:2];
   assign updTag = ex_if.ex_pc[31:IDX_W+2];
   assign updHit = valid_q[updIdx] && (tag_q[updIdx] == updTag);

   // Jumps pin their counter at strongly-taken; only taken misses allocate.
   always_comb begin
      btbWrite  = 1'b0;
      newCtr    = ctr_q[updIdx];
      newTarget = target_q[updIdx];
      if (resolve) begin
         if (updHit && ex_if.ex_is_jump) begin
            btbWrite  = 1'b1;
            newCtr    = 2'b11;
            newTarget = ex_if.ex_target;
         end else if (updHit) begin
            btbWrite = 1'b1;
            if (ex_if.ex_taken) begin
               newCtr    = (ctr_q[updIdx] == 2'b11) ? 2'b11 : ctr_q[updIdx] + 2'd1;
               newTarget = ex_if.ex_target;
            end else begin
               newCtr = (ctr_q[updIdx] == 2'b00) ? 2'b00 : ctr_q[updIdx] - 2'd1;
            end
         end else if (ex_if.ex_taken) begin
            btbWrite  = 1'b1;
            newCtr    = ex_if.ex_is_jump ? 2'b11 : 2'b10;
            newTarget = ex_if.ex_target;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= 32'h0;
            ctr_q[i]    <= 2'b01;
         end
      end else if (btbWrite) begin
         valid_q[updIdx]  <= 1'b1;
         tag_q[updIdx]    <= updTag;
         target_q[updIdx] <= newTarget;
         ctr_q[updIdx]    <= newCtr;
      end
   end

`ifdef PC_CTRL_PERF_EN
   logic [31:0] perfBranches_q, perfMispredicts_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perfBranches_q    <= 32'h0;
         perfMispredicts_q <= 32'h0;
      end else begin
         if (resolve)    perfBranches_q    <= perfBranches_q + 32'd1;
         if (mispredict) perfMispredicts_q <= perfMispredicts_q + 32'd1;
      end
   end

   assign perf_branches_o    = perfBranches_q;
   assign perf_mispredicts_o = perfMispredicts_q;
`else
   assign perf_branches_o    = 32'h0;
   assign perf_mispredicts_o = 32'h0;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: a behavioural fetch/BTB model predicts every
// cycle's outputs into a queue that an independent monitor drains and checks.
module tb_pc_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0;
   localparam int          ENTRIES  = 16;

   typedef struct {
      logic        rstn;
      logic        stall;
      logic        exv;
      logic        br;
      logic        jp;
      logic [31:0] expc;
      logic        taken;
      logic [31:0] tgt;
      logic        ptk;
      logic [31:0] ptgt;
   } stim_t;

   typedef struct {
      int          cycle;
      logic [31:0] pc;
      logic        predTaken;
      logic [31:0] predTarget;
      logic        flush;
      logic [31:0] perfB;
      logic [31:0] perfM;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic [31:0] pc, predTarget, perfB, perfM;
   logic        predTaken;

   pc_ctrl_if exBus ();

   exp_t expQ[$];
   int   tests    = 0;
   int   failures = 0;
   int   cycle    = 0;

   logic        mValid  [ENTRIES];
   logic [31:0] mTagAddr[ENTRIES];
   logic [31:0] mTarget [ENTRIES];
   int          mCtr    [ENTRIES];
   logic [31:0] mPc;
   bit          mRunning;
   logic [31:0] mBranches, mMispredicts;

   always #5 clk = ~clk;

   pc_ctrl #(.BTB_ENTRIES(ENTRIES), .RESET_PC(RESET_PC)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .stall_i           (stall),
      .ex_if             (exBus.slave),
      .pc_o              (pc),
      .pred_taken_o      (predTaken),
      .pred_target_o     (predTarget),
      .perf_branches_o   (perfB),
      .perf_mispredicts_o(perfM)
   );

   function automatic void modelReset();
      for (int i = 0; i < ENTRIES; i++) begin
         mValid[i]   = 1'b0;
         mTagAddr[i] = 32'h0;
         mTarget[i]  = 32'h0;
         mCtr[i]     = 1;
      end
      mPc          = RESET_PC;
      mRunning     = 1'b0;
      mBranches    = 32'h0;
      mMispredicts = 32'h0;
   endfunction

   function automatic stim_t idleS(input logic st);
      stim_t s;
      s.rstn = 1'b1; s.stall = st; s.exv = 1'b0; s.br = 1'b0; s.jp = 1'b0;
      s.expc = 32'h0; s.taken = 1'b0; s.tgt = 32'h0; s.ptk = 1'b0; s.ptgt = 32'h0;
      return s;
   endfunction

   function automatic stim_t resolveS(input logic st, input logic br, input logic jp,
                                      input logic [31:0] expc, input logic taken,
                                      input logic [31:0] tgt, input logic ptk,
                                      input logic [31:0] ptgt);
      stim_t s;
      s.rstn = 1'b1; s.stall = st; s.exv = 1'b1; s.br = br; s.jp = jp;
      s.expc = expc; s.taken = taken; s.tgt = tgt; s.ptk = ptk; s.ptgt = ptgt;
      return s;
   endfunction

   // Drive one cycle, push the expected outputs, then step the model.
   task automatic applyStimulus(input stim_t s);
      exp_t        e;
      int          idx, ui;
      logic        hit, pt, resolve, mis, uh;
      logic [31:0] ptg;
      @(posedge clk);
      #1;
      rst_n                = s.rstn;
      stall                = s.stall;
      exBus.ex_valid       = s.exv;
      exBus.ex_is_branch   = s.br;
      exBus.ex_is_jump     = s.jp;
      exBus.ex_pc          = s.expc;
      exBus.ex_taken       = s.taken;
      exBus.ex_target      = s.tgt;
      exBus.ex_pred_taken  = s.ptk;
      exBus.ex_pred_target = s.ptgt;
      cycle++;
      e.cycle = cycle;
      if (!s.rstn) begin
         modelReset();
         e.pc = RESET_PC; e.predTaken = 1'b0; e.predTarget = 32'h0; e.flush = 1'b0;
         e.perfB = 32'h0; e.perfM = 32'h0;
         expQ.push_back(e);
         return;
      end
      idx     = int'((mPc / 4) % ENTRIES);
      hit     = mValid[idx] && (mTagAddr[idx] == mPc / (4 * ENTRIES));
      pt      = hit && (mCtr[idx] >= 2) && mRunning;
      ptg     = hit ? mTarget[idx] : mPc + 32'd4;
      resolve = s.exv && (s.br || s.jp);
      mis     = resolve && ((s.taken != s.ptk) || (s.taken && (s.tgt != s.ptgt)));
      e.pc = mPc; e.predTaken = pt; e.predTarget = ptg; e.flush = mis;
`ifdef PC_CTRL_PERF_EN
      e.perfB = mBranches; e.perfM = mMispredicts;
`else
      e.perfB = 32'h0; e.perfM = 32'h0;
`endif
      expQ.push_back(e);

      if (!mRunning)      mRunning = 1'b1;
      else if (mis)       mPc = s.taken ? s.tgt : s.expc + 32'd4;
      else if (!s.stall)  mPc = pt ? ptg : mPc + 32'd4;

      if (resolve) begin
         ui = int'((s.expc / 4) % ENTRIES);
         uh = mValid[ui] && (mTagAddr[ui] == s.expc / (4 * ENTRIES));
         if (uh && s.jp) begin
            mCtr[ui] = 3; mTarget[ui] = s.tgt;
         end else if (uh) begin
            if (s.taken) begin
               mCtr[ui] = (mCtr[ui] < 3) ? mCtr[ui] + 1 : 3; mTarget[ui] = s.tgt;
            end else begin
               mCtr[ui] = (mCtr[ui] > 0) ? mCtr[ui] - 1 : 0;
            end
         end else if (s.taken) begin
            mValid[ui] = 1'b1; mTagAddr[ui] = s.expc / (4 * ENTRIES);
            mTarget[ui] = s.tgt; mCtr[ui] = s.jp ? 3 : 2;
         end
         mBranches = mBranches + 32'd1;
      end
      if (mis) mMispredicts = mMispredicts + 32'd1;
   endtask

   // A predicted-taken branch that resolves not-taken redirects fetch to addr.
   task automatic gotoPc(input logic [31:0] addr);
      applyStimulus(resolveS(1'b0, 1'b1, 1'b0, addr - 32'd4, 1'b0, 32'h0, 1'b1, addr));
   endtask

   task automatic checkOutput(input string name, input int cyc,
                              input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", name, cyc, got, want);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #3;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("pc",          e.cycle, pc,                   e.pc);
            checkOutput("pred_taken",  e.cycle, {31'b0, predTaken},   {31'b0, e.predTaken});
            checkOutput("pred_target", e.cycle, predTarget,           e.predTarget);
            checkOutput("flush",       e.cycle, {31'b0, exBus.flush}, {31'b0, e.flush});
            checkOutput("perf_branches",    e.cycle, perfB, e.perfB);
            checkOutput("perf_mispredicts", e.cycle, perfM, e.perfM);
         end
      end
   end

   initial begin : driver
      stim_t s;
      rst_n = 1'b0; stall = 1'b0;
      exBus.ex_valid = 1'b0; exBus.ex_is_branch = 1'b0; exBus.ex_is_jump = 1'b0;
      exBus.ex_pc = 32'h0; exBus.ex_taken = 1'b0; exBus.ex_target = 32'h0;
      exBus.ex_pred_taken = 1'b0; exBus.ex_pred_target = 32'h0;
      modelReset();

      s = idleS(1'b0); s.rstn = 1'b0;
      repeat (2) applyStimulus(s);

      applyStimulus(idleS(1'b1));
      repeat (4) applyStimulus(idleS(1'b0));
      repeat (3) applyStimulus(idleS(1'b1));
      repeat (2) applyStimulus(idleS(1'b0));

      applyStimulus(resolveS(1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 32'h80, 1'b0, 32'h0));
      gotoPc(32'h20);
      applyStimulus(idleS(1'b1));

      repeat (3) applyStimulus(resolveS(1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 32'h80, 1'b1, 32'h80));
      applyStimulus(resolveS(1'b1, 1'b1, 1'b0, 32'h20, 1'b0, 32'h0, 1'b1, 32'h80));
      gotoPc(32'h20);
      applyStimulus(idleS(1'b1));
      applyStimulus(resolveS(1'b1, 1'b1, 1'b0, 32'h20, 1'b0, 32'h0, 1'b1, 32'h80));
      gotoPc(32'h20);
      applyStimulus(idleS(1'b1));
      applyStimulus(idleS(1'b0));

      applyStimulus(resolveS(1'b1, 1'b1, 1'b0, 32'h40, 1'b1, 32'h400, 1'b0, 32'h0));
      applyStimulus(resolveS(1'b1, 1'b1, 1'b0, 32'h80, 1'b1, 32'h500, 1'b0, 32'h0));
      gotoPc(32'h40);
      repeat (2) applyStimulus(idleS(1'b0));

      s = resolveS(1'b0, 1'b0, 1'b1, 32'h44, 1'b1, 32'h900, 1'b0, 32'h0);
      s.rstn = 1'b0;
      applyStimulus(s);
      repeat (2) applyStimulus(idleS(1'b0));
      applyStimulus(resolveS(1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0));
      applyStimulus(resolveS(1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h200));
      applyStimulus(idleS(1'b1));
      gotoPc(32'h100);
      repeat (2) applyStimulus(idleS(1'b0));

      for (int n = 0; n < 600; n++) begin
         int kind;
         s        = idleS($urandom_range(0, 3) == 0);
         s.rstn   = ($urandom_range(0, 99) != 0);
         kind     = $urandom_range(0, 3);
         s.exv    = (kind != 0);
         s.br     = (kind == 1) || (kind == 0 && $urandom_range(0, 1) == 1);
         s.jp     = (kind == 2);
         s.expc   = 32'($urandom_range(0, 63)) << 2;
         s.tgt    = 32'($urandom_range(0, 63)) << 2;
         s.taken  = s.jp ? 1'b1 : 1'($urandom_range(0, 1));
         s.ptk    = 1'($urandom_range(0, 1));
         s.ptgt   = ($urandom_range(0, 1) == 1) ? s.tgt : 32'($urandom_range(0, 63)) << 2;
         applyStimulus(s);
      end

      repeat (3) @(posedge clk);
      tests++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", expQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Fetch-side program-counter controller. It owns the architectural fetch PC, chooses the next PC every cycle, and predicts branch targets with a small direct-mapped branch target buffer (BTB) that uses 2-bit saturating counters. It also redirects fetch and raises flush when the EX stage resolves a mispredicted branch or jump. It sits between the hazard unit (stall) and the EX-stage branch resolution logic, and it drives the instruction-memory address.

Parameters:
- BTB_ENTRIES, 16: number of BTB entries; must be a power of 2, minimum 2. IDX_W = log2(BTB_ENTRIES).
- RESET_PC, 32'h0000_0000: fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- stall  in  1  hazard-unit request to hold the PC.
- ex_valid  in  1  EX stage holds a resolved control-flow instruction this cycle.
- ex_is_branch  in  1  the resolved instruction is a conditional branch.
- ex_is_jump  in  1  the resolved instruction is an unconditional jump (JAL/JALR).
- ex_pc  in  32  PC of the resolved instruction.
- ex_taken  in  1  actual outcome; forced to 1 for jumps by the EX stage.
- ex_target  in  32  actual taken target.
- ex_pred_taken  in  1  prediction that was carried down the pipe with this instruction.
- ex_pred_target  in  32  predicted target that was carried down the pipe.
- PC  out  32  current fetch PC.
- pred_taken  out  1  prediction for the current PC.
- pred_target  out  32  predicted target for the current PC.
- flush  out  1  misprediction; flush IF/ID and ID/EX.
- perf_branches  out  32  count of resolved control-flow instructions (optional feature).
- perf_mispredicts  out  32  count of mispredictions (optional feature).

Behaviour:
- FSM states: S_HOLD and S_RUN.
  - Reset (rst_n=0, asynchronous) forces state=S_HOLD, PC=RESET_PC, all BTB valid bits=0, all counters=2'b01.
  - With reset asserted: pred_taken=0, pred_target=0, flush=0.
- S_HOLD:
  - PC stays at RESET_PC for exactly one clock after reset release, then the FSM moves to S_RUN.
  - Prediction is suppressed (pred_taken=0).
  - stall is ignored in this state.
- Lookup (combinational on PC):
  - idx = PC[IDX_W+1:2], tag = PC[31:IDX_W+2].
  - hit = valid[idx] && tag[idx]==tag.
  - pred_taken = hit && ctr[idx][1] && state==S_RUN.
  - pred_target = target[idx] when hit, else PC+4.
- Mispredict (combinational):
  - mispredict = ex_valid && (ex_is_branch || ex_is_jump) && ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target)).
  - flush = mispredict, asserted in the same cycle.
- Corrected PC: ex_taken ? ex_target : ex_pc+4. Arithmetic is 32-bit and wraps modulo 2^32.
- Next-PC priority in S_RUN, highest first:
  1. mispredict: load corrected PC. This overrides stall.
  2. stall: PC holds.
  3. pred_taken: load pred_target.
  4. otherwise: load PC+4.
- BTB update, at the posedge where ex_valid && (ex_is_branch || ex_is_jump):
  - Entry is selected by the idx and tag of ex_pc.
  - Hit, branch: counter saturating +1 if taken, -1 if not taken (range 00..11). Target is rewritten with ex_target when taken.
  - Hit, jump: counter is set to 11 and the target is rewritten.
  - Miss, taken (branch or jump): allocate the entry, overwriting any previous occupant. Set valid=1, tag, target=ex_target, counter=10 for a branch or 11 for a jump.
  - Miss, not taken: no allocation.
  - Updates occur regardless of stall.
- Lookup and update to the same idx in the same cycle: the lookup returns the pre-update contents. The new contents become visible in the next cycle.
- ex_valid with neither ex_is_branch nor ex_is_jump: no update and no mispredict.
- Reset mid-operation: takes effect immediately. Any in-flight redirect is discarded and the BTB is fully invalidated.

Optional Feature:
- Macro PC_CTRL_PERF_EN.
- When defined:
  - perf_branches increments on every ex_valid && (ex_is_branch || ex_is_jump).
  - perf_mispredicts increments on every mispredict.
  - Both counters are 32-bit, wrap at 2^32, reset to 0 and count during stall.
- When undefined: both outputs are tied to 32'h0 and no counter flops are instantiated.

Test Plan:
- Reset hold:
  - Stimulus: release rst_n, with stall=1 driven during S_HOLD.
  - Required response: PC=0x0 for two consecutive posedges. PC then steps 0x4, 0x8 (stall still low).
- Stall:
  - Stimulus: PC=0x10, assert stall for 3 cycles.
  - Required response: PC stays 0x10. Deassert stall → PC=0x14 next cycle.
- Cold mispredict:
  - Stimulus: ex_valid, branch, ex_pc=0x20, ex_taken=1, ex_target=0x80, ex_pred_taken=0, with stall=1.
  - Required response: flush=1 in the same cycle; PC=0x80 next cycle.
  - BTB check: when PC later reaches 0x20, pred_taken=1 and pred_target=0x80.
- Counter saturation and hysteresis:
  - Stimulus: resolve 0x20 taken three more times (counter reaches 11), then not-taken once.
  - Required response: pred_taken stays 1 at 0x20. After a second not-taken, pred_taken=0.
- Aliasing (BTB_ENTRIES=16):
  - Stimulus: taken branch at 0x40 allocates; then a taken branch at 0x80 (same idx, different tag) is resolved.
  - Required response: lookup at PC=0x40 gives hit=0, pred_taken=0, next PC=0x44.
- Jump target change with PC_CTRL_PERF_EN defined:
  - Stimulus: a jump at 0x100 resolves to 0x200 and then to 0x300, with ex_pred_target=0x200 on the second resolution.
  - Required response: flush on both resolutions; perf_branches=2, perf_mispredicts=2.
